rangefinder_sopc_keys_port: RTL and testbench

Avalon-MM slave input PIO: the read-side counterpart of the LED output port, used for push-buttons and switches on the rangefinder board. Synchronizes and debounces each external input bit and exposes the stable levels on a register. Captures configured edges in sticky bits and raises a maskable interrupt to the Nios II IRQ line. Same zero-wait-state slave timing and 3-bit word address space as the other PIO ports.

---
 rtl/rangefinder_sopc_keys_port_pkg.sv | 22 ++
 rtl/rangefinder_sopc_keys_port_debounce.sv | 74 +++++++
 rtl/rangefinder_sopc_keys_port.sv | 103 ++++++++++
 tb/tb_rangefinder_sopc_keys_port.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rangefinder_sopc_keys_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rangefinder_sopc_keys_port_pkg
//  Description : Shared constants for the rangefinder keys/switches input PIO:
//                register word addresses and edge-capture mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package rangefinder_sopc_keys_port_pkg;

    // Avalon word addresses of the PIO registers (addresses 4..7 are unmapped)
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;

    // Which transitions of the debounced level are captured
    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage : rangefinder_sopc_keys_port_pkg
`default_nettype wire

// File: rtl/rangefinder_sopc_keys_port_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : rangefinder_sopc_keys_port_debounce
//  Description : Single-bit input conditioner. Two-flop synchronizer followed
//                by a debounce counter; the stable level only follows the
//                synchronized input after it has differed for DEBOUNCE_CYCLES
//                consecutive cycles. change pulses (combinationally) in the
//                cycle whose closing edge updates the stable level; rise gives
//                the direction of that update.
//  Revision    : 1.0 - initial release
// ============================================================================
module rangefinder_sopc_keys_port_debounce
    import rangefinder_sopc_keys_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_raw,
    output logic stable,
    output logic change,
    output logic rise
);

    // Counter only ever reaches DEBOUNCE_CYCLES-1 before it clears
    localparam int unsigned        c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_differs;
    logic               w_accept;

    // Synchronized level disagrees with the accepted one; accept on the edge
    // that completes DEBOUNCE_CYCLES consecutive disagreeing cycles
    assign w_differs = (r_sync2 != r_stable);
    assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);

    // Two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VALUE;
            r_sync2 <= RESET_VALUE;
        end else begin
            r_sync1 <= in_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter and accepted level; any return to the stable level clears progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= RESET_VALUE;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else if (w_differs) begin
            r_cnt    <= r_cnt + 1'b1;
        end else begin
            r_cnt    <= '0;
        end
    end

    assign stable = r_stable;
    assign change = w_accept;
    assign rise   = r_sync2;

endmodule : rangefinder_sopc_keys_port_debounce
`default_nettype wire

// File: rtl/rangefinder_sopc_keys_port.sv
`default_nettype none
// ============================================================================
//  Module      : rangefinder_sopc_keys_port
//  Description : Avalon-MM slave input PIO for push-buttons and switches.
//                Per-bit synchronize + debounce, readable data register,
//                sticky edge capture (write-1-to-clear) and a maskable
//                level interrupt. Zero-wait-state, read latency 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rangefinder_sopc_keys_port
    import rangefinder_sopc_keys_port_pkg::*;
#(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_change;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clear;
    logic             w_wr;
    logic             w_unused;

    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;

    // One conditioner per input bit
    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            rangefinder_sopc_keys_port_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VALUE     (RESET_VALUE[i])
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .in_raw  (in_port[i]),
                .stable  (w_stable[i]),
                .change  (w_change[i]),
                .rise    (w_rise[i])
            );
        end
    endgenerate

    assign w_wr = chipselect & ~write_n;

    // Debounced transitions that match the configured edge type
    assign w_set = (EDGE_TYPE == EDGE_RISING)  ? (w_change &  w_rise) :
                   (EDGE_TYPE == EDGE_FALLING) ? (w_change & ~w_rise) :
                                                  w_change;

    // Bits requested cleared by a write-1-to-clear access
    assign w_clear = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_wr && (address == ADDR_IRQMASK)) begin
            r_irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge beats a coincident clear so none is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_capture <= '0;
        end else begin
            r_edge_capture <= (r_edge_capture & ~w_clear) | w_set;
        end
    end

    // Zero-latency read mux; unmapped addresses and upper bits read zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(w_stable);
            ADDR_DIR:     readdata = '0;
            ADDR_IRQMASK: readdata = 32'(r_irq_mask);
            ADDR_EDGECAP: readdata = 32'(r_edge_capture);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(r_edge_capture & r_irq_mask);

    // Upper writedata bits are not stored when WIDTH < 32
    assign w_unused = &{1'b0, writedata};

endmodule : rangefinder_sopc_keys_port
`default_nettype wire

// File: tb/tb_rangefinder_sopc_keys_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rangefinder_sopc_keys_port
//  Description : Directed self-checking bench for the keys input PIO with a
//                window-based behavioural model checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rangefinder_sopc_keys_port;

    localparam int W = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rangefinder_sopc_keys_port #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .EDGE_TYPE       (1),
        .RESET_VALUE     (8'hFF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // ------------------------------------------------------------------
    // Behavioural model: the stable level flips when the input as seen two
    // edges late has disagreed with it over the last D samples.
    // ------------------------------------------------------------------
    logic [W-1:0] m_stable, m_cap, m_mask;
    logic [W-1:0] hist [0:D];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_stable = 8'hFF;
            m_cap    = '0;
            m_mask   = '0;
            for (int j = 0; j <= D; j++) hist[j] = 8'hFF;
        end else begin
            logic [W-1:0] nxt, set, clr;
            nxt = m_stable;
            for (int b = 0; b < W; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) nxt[b] = ~m_stable[b];
            end
            set = m_stable & ~nxt;
            clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
            if (chipselect && !write_n && address == 3'd2) m_mask = writedata[W-1:0];
            m_cap    = (m_cap & ~clr) | set;
            m_stable = nxt;
            for (int j = D; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = in_port;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {24'b0, m_stable};
            3'd2:    return {24'b0, m_mask};
            3'd3:    return {24'b0, m_cap};
            default: return 32'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle comparison against the model, just after each active edge
    always @(posedge clk) begin
        #1;
        check("cyc_readdata", readdata, exp_rd(address));
        check("cyc_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 8'hFF;
        repeat (3) @(negedge clk);
        #1;
        check("in_reset_data", readdata, 32'h000000FF);
        check("in_reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state of the register map
        read_check(3'd0, 32'h000000FF, "rst_data");
        read_check(3'd2, 32'h0, "rst_mask");
        read_check(3'd3, 32'h0, "rst_cap");
        read_check(3'd1, 32'h0, "dir_reads_0");
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Writes to data and direction are ignored
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'hFF);
        read_check(3'd0, 32'h000000FF, "data_read_only");

        // Bit 0 falls: stable update exactly 6 edges after the change
        @(negedge clk);
        in_port = 8'hFE; address = 3'd0;
        repeat (5) @(posedge clk);
        #1 check("deb_not_early", readdata, 32'h000000FF);
        @(posedge clk);
        #1 check("deb_latency", readdata, 32'h000000FE);
        read_check(3'd3, 32'h01, "cap_bit0");
        check("irq_masked", {31'b0, irq}, 32'h0);

        // 3-cycle glitch on bit 3 is rejected
        @(negedge clk);
        in_port = 8'hF6;
        repeat (3) @(negedge clk);
        in_port = 8'hFE;
        repeat (10) @(negedge clk);
        read_check(3'd0, 32'h000000FE, "glitch_data");
        read_check(3'd3, 32'h01, "glitch_cap");

        // Unmask bit 0 -> irq; W1C bit 0 -> irq drops
        bus_write(3'd2, 32'h01);
        check("irq_on_mask", {31'b0, irq}, 32'h1);
        bus_write(3'd3, 32'h01);
        check("irq_off_w1c", {31'b0, irq}, 32'h0);
        read_check(3'd3, 32'h0, "cap_cleared");

        // W1C of bit 2 coincides with bit 2's capture edge: set wins
        bus_write(3'd2, 32'h04);
        check("irq_mask2_idle", {31'b0, irq}, 32'h0);
        @(negedge clk);
        in_port = 8'hFA;
        repeat (5) @(negedge clk);
        address = 3'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        check("w1c_vs_set_cap", readdata, 32'h04);
        check("w1c_vs_set_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        read_check(3'd0, 32'h000000FA, "data_bit2_low");
        bus_write(3'd3, 32'h04);
        check("irq_cleared2", {31'b0, irq}, 32'h0);

        // Reset in the middle of bit 5's debounce discards progress
        @(negedge clk);
        in_port = 8'hDA; address = 3'd0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1 check("async_rst_data", readdata, 32'h000000FF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1; address = 3'd3;
        repeat (5) @(posedge clk);
        #1 check("rst_no_early_cap", readdata, 32'h0);
        @(posedge clk);
        #1 check("rst_capture", readdata, 32'h25);
        read_check(3'd0, 32'h000000DA, "rst_data_after");
        check("rst_irq_after", {31'b0, irq}, 32'h0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_rangefinder_sopc_keys_port
`default_nettype wire
